// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit feeding the HI/LO registers.
// Each multiply step is one shift-add. Each divide step is one restoring subtract.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_divz;
  logic [31:0] r_mcand;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_start;
  logic        w_last;
  logic [32:0] w_sum;
  logic [63:0] w_acc_mul;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [32:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [63:0] w_prod_f;
  logic [31:0] w_quo_f;
  logic [31:0] w_rem_f;

  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && a[31]) ? (32'd0 - a) : a;
  assign w_b_mag  = (w_signed && b[31]) ? (32'd0 - b) : b;
  assign w_start  = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_count == 5'd31);

  // Multiply: the high half accumulates and the multiplier shifts out of the low half.
  assign w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_acc_mul = {w_sum, r_acc[31:1]};

  // Divide: the dividend shifts out of r_acc[31:0]. Quotient bits shift in behind it.
  assign w_shift    = {r_rem[31:0], r_acc[31]};
  assign w_ge       = (w_shift >= {1'b0, r_mcand});
  assign w_rem_next = w_ge ? (w_shift - {1'b0, r_mcand}) : w_shift;
  assign w_quo_next = {r_acc[30:0], w_ge};

  assign w_prod_f = r_neg_q ? (64'd0 - w_acc_mul) : w_acc_mul;
  assign w_quo_f  = r_divz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_quo_next) : w_quo_next);
  // A zero divisor leaves the remainder at |a|. Restoring the sign of a gives back a unchanged.
  assign w_rem_f  = r_neg_r ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == 5'd31) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count  <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_mcand  <= 32'd0;
      r_acc    <= 64'd0;
      r_rem    <= 33'd0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_count  <= 5'd0;
        r_is_div <= op[1];
        r_neg_q  <= w_signed & (a[31] ^ b[31]);
        r_neg_r  <= w_signed & op[1] & a[31];
        r_divz   <= op[1] & (b == 32'd0);
        r_rem    <= 33'd0;
        if (op[1]) begin
          r_mcand <= w_b_mag;
          r_acc   <= {32'd0, w_a_mag};
        end else begin
          r_mcand <= w_a_mag;
          r_acc   <= {32'd0, w_b_mag};
        end
      end else if (r_state == S_RUN) begin
        r_count <= r_count + 5'd1;
        if (r_is_div) begin
          r_rem <= w_rem_next;
          r_acc <= {32'd0, w_quo_next};
        end else begin
          r_acc <= w_acc_mul;
        end
        if (w_last) begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem_f;
            r_lo <= w_quo_f;
          end else begin
            r_hi <= w_prod_f[63:32];
            r_lo <= w_prod_f[31:0];
          end
        end
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign hi_write = r_done;
  assign lo_write = r_done;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Checks latency, the done pulse, the hold behaviour of the result registers and the special cases.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks;
  int n_errors;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the inputs so late changes are exercised.
  task automatic issue(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(negedge clk);
    start = 1'b0;
    op    = ~t_op;
    a     = ~t_a;
    b     = t_b ^ 32'h5A5A_5A5A;
  endtask

  // Called just after the start edge. Optionally pulses a rival start at cycle mid.
  task automatic expect_done(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int mid);
    int early;
    early = 0;
    check_eq({tag, "_busy0"}, {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 31; i++) begin
      if (i == mid) begin
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) early++;
    end
    start = 1'b0;
    check_eq({tag, "_early"}, early, 64'd0);
    check_eq({tag, "_busy31"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    check_eq({tag, "_done"}, {61'd0, done, hi_write, lo_write}, 64'd7);
    check_eq({tag, "_busyd"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
    check_eq({tag, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", {58'd0, busy, done, hi_write, lo_write, 2'b00}, 64'd0);
    check_eq("rst_hilo", {hi_out, lo_out}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    expect_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    @(negedge clk);
    check_eq("mult_pulse", {61'd0, done, hi_write, lo_write}, 64'd0);
    check_eq("mult_hold", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, -1);
    @(negedge clk);
    issue(2'b01, 32'd7, 32'd6);
    expect_done("multu_42", 32'd0, 32'd42, -1);
    @(negedge clk);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    expect_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    @(negedge clk);
    issue(2'b11, 32'd7, 32'd2);
    expect_done("divu_7_2", 32'd1, 32'd3, -1);
    @(negedge clk);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_done("div_ovf", 32'd0, 32'h8000_0000, -1);
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd0);
    expect_done("divu_z", 32'h0000_0064, 32'hFFFF_FFFF, -1);
    @(negedge clk);
    issue(2'b10, 32'hFFFF_FFFB, 32'd0);
    expect_done("div_z", 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);
    @(negedge clk);

    // A start pulsed while busy must not restart or change the running operation.
    issue(2'b01, 32'd3, 32'd4);
    expect_done("ign_start", 32'd0, 32'd12, 10);
    @(negedge clk);

    // Reset in the middle of an operation aborts it.
    issue(2'b01, 32'd3, 32'd4);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("abort_state", {62'd0, busy, done}, 64'd0);
    check_eq("abort_hilo", {hi_out, lo_out}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check_eq("abort_quiet", seen, 64'd0);
    issue(2'b01, 32'd5, 32'd6);
    expect_done("post_rst", 32'd0, 32'd30, -1);
    @(negedge clk);

    // Start a second request in the done cycle of the first one.
    issue(2'b01, 32'd2, 32'd3);
    expect_done("b2b_1", 32'd0, 32'd6, -1);
    issue(2'b11, 32'd9, 32'd4);
    check_eq("b2b_hold", {32'd0, lo_out}, 64'd6);
    expect_done("b2b_2", 32'd1, 32'd2, -1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
